// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
// Sizes are common with register_file; the beat struct is the unit streamed to the debug link.
package rf_dbg_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2
    } dump_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } dump_beat_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug master: borrows the rs1 read port, walks a (possibly wrapping) register range
// and streams (addr, data) beats over valid/ready with a running XOR checksum.
//
// state | meaning
// IDLE  | waiting for start_i; checksum holds the last dump's value
// READ  | rs1 port requested; capture rf data on grant
// SEND  | beat presented on dump_*; advance or finish on handshake
module regfile_dump_reader
    import rf_dbg_pkg::*;
#(
    parameter int NUM_REGS = rf_dbg_pkg::NUM_REGS,
    parameter int ADDR_W   = rf_dbg_pkg::ADDR_W,
    parameter int DATA_W   = rf_dbg_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rf_rd_req_o,
    input  logic              rf_rd_gnt_i,
    output logic [ADDR_W-1:0] rf_rd_addr_o,
    input  logic [DATA_W-1:0] rf_rd_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic [DATA_W-1:0] checksum_o
);

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_end_addr;
    logic [DATA_W-1:0] r_checksum;
    dump_beat_t        r_beat;
    logic              r_done;

    logic              w_launch;
    logic              w_capture;
    logic              w_accept;
    logic              w_abort;
    logic [ADDR_W-1:0] w_cur_inc;

    // Explicit wrap keeps the walk modulo NUM_REGS even when it is not a power of two.
    assign w_cur_inc = (r_cur_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_cur_addr + ADDR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (abort_i) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (rf_rd_gnt_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort_i) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (dump_ready_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = r_beat.last ? ST_IDLE : ST_READ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cur_addr <= '0;
            r_end_addr <= '0;
            r_checksum <= '0;
            r_beat     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_accept && r_beat.last;
            if (w_launch) begin
                r_cur_addr <= first_addr_i;
                r_end_addr <= last_addr_i;
                r_checksum <= '0;
            end
            if (w_capture) begin
                r_beat.addr <= r_cur_addr;
                r_beat.data <= rf_rd_data_i;
                r_beat.last <= (r_cur_addr == r_end_addr);
            end
            if (w_accept) begin
                r_checksum  <= r_checksum ^ r_beat.data;
                r_beat.last <= 1'b0;
                if (!r_beat.last) begin
                    r_cur_addr <= w_cur_inc;
                end
            end
            // Abort drops the beat without a handshake; checksum keeps its partial value.
            if (w_abort) begin
                r_beat.last <= 1'b0;
            end
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign rf_rd_req_o  = (r_state == ST_READ) || (r_state == ST_SEND);
    assign rf_rd_addr_o = r_cur_addr;
    assign dump_valid_o = (r_state == ST_SEND);
    assign dump_addr_o  = r_beat.addr;
    assign dump_data_o  = r_beat.data;
    assign dump_last_o  = r_beat.last;
    assign checksum_o   = r_checksum;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: models the register file, collects accepted
// beats at the falling edge and compares them with hand-computed expectations.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [4:0]  first_addr_i = '0;
    logic [4:0]  last_addr_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        rf_rd_req_o;
    logic        rf_rd_gnt_i = 1'b1;
    logic [4:0]  rf_rd_addr_o;
    logic [31:0] rf_rd_data_i;
    logic        dump_valid_o;
    logic        dump_ready_i = 1'b1;
    logic [4:0]  dump_addr_o;
    logic [31:0] dump_data_o;
    logic        dump_last_o;
    logic [31:0] checksum_o;

    logic [31:0] rf_mem [32];
    logic [4:0]  q_addr [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .first_addr_i (first_addr_i),
        .last_addr_i  (last_addr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .rf_rd_req_o  (rf_rd_req_o),
        .rf_rd_gnt_i  (rf_rd_gnt_i),
        .rf_rd_addr_o (rf_rd_addr_o),
        .rf_rd_data_i (rf_rd_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .checksum_o   (checksum_o)
    );

    always_comb rf_rd_data_i = rf_mem[rf_rd_addr_o];

    always @(negedge clk) begin
        if (reset_n) begin
            if (dump_valid_o && dump_ready_i && !abort_i) begin
                q_addr.push_back(dump_addr_o);
                q_data.push_back(dump_data_o);
                q_last.push_back(dump_last_o);
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_data(input int a);
        return (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a);
    endfunction

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        first_addr_i = f;
        last_addr_i  = l;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        if (busy_o) check({tag, "_timeout"}, 64'(busy_o), 64'd0);
        tick();
    endtask

    task automatic check_beats(input string tag, input int base, input int first, input int n,
                               input logic last_at_end);
        check({tag, "_count"}, 64'(q_addr.size() - base), 64'(n));
        for (int k = 0; k < n && (base + k) < q_addr.size(); k++) begin
            int a = (first + k) % 32;
            check($sformatf("%s_addr%0d", tag, k), 64'(q_addr[base + k]), 64'(a));
            check($sformatf("%s_data%0d", tag, k), 64'(q_data[base + k]), 64'(exp_data(a)));
            check($sformatf("%s_last%0d", tag, k), 64'(q_last[base + k]),
                  64'(last_at_end && (k == n - 1)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy_o),       64'd0);
        check({tag, "_done"},  64'(done_o),       64'd0);
        check({tag, "_req"},   64'(rf_rd_req_o),  64'd0);
        check({tag, "_raddr"}, 64'(rf_rd_addr_o), 64'd0);
        check({tag, "_valid"}, 64'(dump_valid_o), 64'd0);
        check({tag, "_last"},  64'(dump_last_o),  64'd0);
        check({tag, "_daddr"}, 64'(dump_addr_o),  64'd0);
        check({tag, "_ddata"}, 64'(dump_data_o),  64'd0);
        check({tag, "_csum"},  64'(checksum_o),   64'd0);
    endtask

    initial begin
        int base;
        int dbase;
        int n;

        for (int i = 0; i < 32; i++) rf_mem[i] = exp_data(i);

        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Full 0..31 dump, latency, and a start pulse while busy that must be ignored.
        base  = q_addr.size();
        dbase = done_cnt;
        start_dump(5'd0, 5'd31);
        check("full_lat_cyc1_valid", 64'(dump_valid_o), 64'd0);
        check("full_busy", 64'(busy_o), 64'd1);
        tick();
        check("full_lat_cyc2_valid", 64'(dump_valid_o), 64'd1);
        first_addr_i = 5'd3;
        last_addr_i  = 5'd4;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        wait_idle(300, "full");
        check_beats("full", base, 0, 32, 1'b1);
        check("full_done", 64'(done_cnt - dbase), 64'd1);
        check("full_csum", 64'(checksum_o), 64'h1000_0000);
        tick();
        tick();
        check("full_csum_hold", 64'(checksum_o), 64'h1000_0000);

        // Wrapping range 30,31,0,1.
        base  = q_addr.size();
        dbase = done_cnt;
        start_dump(5'd30, 5'd1);
        wait_idle(50, "wrap");
        check_beats("wrap", base, 30, 4, 1'b1);
        check("wrap_done", 64'(done_cnt - dbase), 64'd1);
        check("wrap_csum", 64'(checksum_o), 64'h1000_0000);

        // Single beat held under back-pressure.
        base  = q_addr.size();
        dbase = done_cnt;
        dump_ready_i = 1'b0;
        start_dump(5'd5, 5'd5);
        tick();
        for (int s = 0; s < 4; s++) begin
            check($sformatf("stall_valid%0d", s), 64'(dump_valid_o), 64'd1);
            check($sformatf("stall_addr%0d", s),  64'(dump_addr_o),  64'd5);
            check($sformatf("stall_data%0d", s),  64'(dump_data_o),  64'h1000_0005);
            check($sformatf("stall_last%0d", s),  64'(dump_last_o),  64'd1);
            tick();
        end
        check("stall_no_accept", 64'(q_addr.size() - base), 64'd0);
        dump_ready_i = 1'b1;
        wait_idle(20, "stall");
        check_beats("stall", base, 5, 1, 1'b1);
        check("stall_done", 64'(done_cnt - dbase), 64'd1);
        check("stall_csum", 64'(checksum_o), 64'h1000_0005);

        // Grant withheld for 3 cycles while reading x7.
        base  = q_addr.size();
        dbase = done_cnt;
        start_dump(5'd6, 5'd8);
        n = 0;
        while (!(rf_rd_req_o && !dump_valid_o && rf_rd_addr_o == 5'd7) && n < 20) begin
            tick();
            n++;
        end
        check("gnt_reach_addr7", 64'(n < 20), 64'd1);
        rf_rd_gnt_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check($sformatf("gnt_wait_valid%0d", s), 64'(dump_valid_o), 64'd0);
            check($sformatf("gnt_wait_busy%0d", s),  64'(busy_o),       64'd1);
        end
        rf_rd_gnt_i = 1'b1;
        wait_idle(30, "gnt");
        check_beats("gnt", base, 6, 3, 1'b1);
        check("gnt_done", 64'(done_cnt - dbase), 64'd1);
        check("gnt_csum", 64'(checksum_o), 64'h1000_0009);

        // Abort while beat 10 is presented.
        base  = q_addr.size();
        dbase = done_cnt;
        start_dump(5'd0, 5'd31);
        n = 0;
        while (!(dump_valid_o && dump_addr_o == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_addr10", 64'(n < 100), 64'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_valid", 64'(dump_valid_o), 64'd0);
        check("abort_busy",  64'(busy_o),       64'd0);
        check("abort_req",   64'(rf_rd_req_o),  64'd0);
        tick();
        tick();
        check_beats("abort", base, 0, 10, 1'b0);
        check("abort_no_done", 64'(done_cnt - dbase), 64'd0);
        check("abort_csum", 64'(checksum_o), 64'h1000_0001);

        // Asynchronous reset in the middle of a dump, then a fresh 0..3 dump.
        start_dump(5'd0, 5'd31);
        for (int s = 0; s < 5; s++) tick();
        check("rst_mid_busy_before", 64'(busy_o), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        check_all_zero("rst_hold");
        reset_n = 1'b1;
        tick();
        base  = q_addr.size();
        dbase = done_cnt;
        start_dump(5'd0, 5'd3);
        wait_idle(30, "post_rst");
        check_beats("post_rst", base, 0, 4, 1'b1);
        check("post_rst_done", 64'(done_cnt - dbase), 64'd1);
        check("post_rst_csum", 64'(checksum_o), 64'h1000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug/inspection master that reads a contiguous range of integer registers out of the register file through a borrowed read port. It streams each (address, data) pair over a valid/ready interface to the debug link or trace buffer. It is the read-side counterpart of the writeback path: it requests the rs1 read port, walks the addresses and serializes the contents. It sits beside decode and shares rs1 through an external mux that is controlled by the request/grant pair.

Parameters:
NUM_REGS, 32, number of architectural registers; address arithmetic is modulo NUM_REGS.
ADDR_W, 5, register address width, equal to clog2(NUM_REGS).
DATA_W, 32, register data width.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start_i  in  1  begin a dump; sampled only in IDLE.
abort_i  in  1  cancel the dump in progress.
first_addr_i  in  ADDR_W  first register to read; sampled with start_i.
last_addr_i  in  ADDR_W  last register to read; sampled with start_i.
busy_o  out  1  high in every state except IDLE.
done_o  out  1  one-cycle pulse when the final beat is accepted.
rf_rd_req_o  out  1  requests ownership of the rs1 read port.
rf_rd_gnt_i  in  1  port granted; the mux routes rf_rd_addr_o to rs1.
rf_rd_addr_o  out  ADDR_W  read address driven to the register file.
rf_rd_data_i  in  DATA_W  rs1 data; combinational read of rf_rd_addr_o.
dump_valid_o  out  1  output beat valid.
dump_ready_i  in  1  sink accepts the beat.
dump_addr_o  out  ADDR_W  register index of the current beat.
dump_data_o  out  DATA_W  register contents of the current beat.
dump_last_o  out  1  current beat is the final one of the range.
checksum_o  out  DATA_W  running XOR of all accepted beats in this dump.

Behaviour:
- Reset (asynchronous, any state, including mid-dump):
  - FSM goes to IDLE.
  - busy_o, done_o, rf_rd_req_o, dump_valid_o and dump_last_o are 0.
  - rf_rd_addr_o, dump_addr_o, dump_data_o and checksum_o are 0.
- FSM states: IDLE, READ, SEND.
- IDLE:
  - start_i=1 latches cur_addr<=first_addr_i and end_addr<=last_addr_i, and clears checksum to 0.
  - Next state is READ.
- READ:
  - rf_rd_req_o=1 and rf_rd_addr_o=cur_addr.
  - If rf_rd_gnt_i=1 at the clock edge: dump_data_o<=rf_rd_data_i, dump_addr_o<=cur_addr, dump_last_o<=(cur_addr==end_addr), dump_valid_o<=1, next state SEND.
  - If rf_rd_gnt_i=0: stay in READ and capture nothing.
- SEND:
  - rf_rd_req_o stays 1 so the port is not relinquished between beats.
  - dump_* outputs are held stable while valid && !ready.
  - On valid&&ready: checksum<=checksum^dump_data_o and dump_valid_o<=0.
  - If dump_last_o: done_o pulses 1 on the next cycle and the FSM goes to IDLE.
  - Otherwise: cur_addr<=(cur_addr+1) mod NUM_REGS and the FSM goes to READ.
- Throughput: at best one beat per 2 cycles (READ then SEND). Latency from start_i to the first dump_valid_o is 2 cycles with grant held.
- Range wrap: if first_addr>last_addr the range wraps, e.g. 30,31,0,1.
- first_addr==last_addr gives exactly one beat with dump_last_o=1.
- A full 0..31 dump is 32 beats.
- Register 0 is forwarded as read; the register file returns 0, so x0 beats carry 0.
- start_i while busy is ignored. The latched range cannot change mid-dump.
- abort_i in READ or SEND:
  - Next edge returns to IDLE with dump_valid_o=0 and rf_rd_req_o=0.
  - No done_o pulse; checksum_o keeps its partial value.
  - Abort is the only case where valid may drop without a handshake.
- abort_i has priority over start_i and over a simultaneous handshake in the same cycle.
- Grant deasserted during SEND is legal and has no effect until the next READ.
- checksum_o holds its last value in IDLE until the next start.

Decomposition:
- Shared package rf_dbg_pkg holds:
  - the FSM state enum (IDLE/READ/SEND, 2 bits);
  - constants NUM_REGS=32, ADDR_W=5, DATA_W=32, shared with register_file;
  - a typedef for the dump beat struct {addr, data, last}.
- No sub-module is needed; a single FSM plus an output register.
- The rs1 port-sharing mux lives in the core top level, not in this block.

Test Plan:
- Preload x1..x31 with 0x1000_0000+i, then start first=0 last=31 with ready=1 and grant=1.
  - Required: 32 beats, addr 0..31; data 0 for x0, 0x1000_0000+i otherwise.
  - Required: last only on addr 31, done pulse once, checksum = XOR of all the data.
- Start first=30 last=1.
  - Required: beats at addr 30,31,0,1 in that order; last on addr 1.
- Start first=5 last=5 with dump_ready_i low for 4 cycles.
  - Required: a single beat, data/addr held stable while stalled, accepted when ready rises, last=1, done pulse.
- Deassert rf_rd_gnt_i for 3 cycles in READ at addr 7.
  - Required: no beat until grant returns; the beat then carries the x7 value, with no skip or duplicate.
- abort_i during SEND of addr 10 in a 0..31 dump.
  - Required: valid=0 and busy=0 next cycle; no done pulse; checksum equals the XOR of beats 0..9.
- reset_n low mid-dump, then a fresh start 0..3.
  - Required: all outputs 0 during reset; the new dump emits 4 beats and its checksum starts from 0.
